// File: rtl/spi_slave_shift_engine_if.sv
// Bus bundle between an SPI master-side driver and spi_slave_shift_engine:
// the serial pins plus the pclk-domain transmit/receive handshakes.
interface spi_slave_shift_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi0;
  logic                  miso0;
  logic [DATA_WIDTH-1:0] txData;
  logic                  txValid;
  logic                  txReady;
  logic [DATA_WIDTH-1:0] rxData;
  logic                  rxValid;
  logic                  rxReady;
  logic                  rxOverrun;
  logic                  txUnderrun;
  logic                  frameAbort;

  modport slave (
    input  sclk, cs, mosi0, txData, txValid, rxReady,
    output miso0, txReady, rxData, rxValid, rxOverrun, txUnderrun, frameAbort
  );

  modport master (
    output sclk, cs, mosi0, txData, txValid, rxReady,
    input  miso0, txReady, rxData, rxValid, rxOverrun, txUnderrun, frameAbort
  );
endinterface

// File: rtl/spi_slave_shift_engine.sv
// Single-lane SPI slave: oversamples sclk/cs/mosi0 on pclk, shifts one word per
// chip-select frame and exchanges words through valid/ready handshakes.
module spi_slave_shift_engine #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic                     pclk,
  input logic                     areset,
  spi_slave_shift_engine_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  logic                  tx_full;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  shift_pending;
  logic                  miso_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_overrun_q;
  logic                  tx_underrun_q;
  logic                  frame_abort_q;

  // Synchronizers reset to the bus idle levels so reset release never looks like an edge.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sclk_meta <= CPOL;
      sclk_sync <= CPOL;
      sclk_prev <= CPOL;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge value of its source,
      // which is what makes this a chain of stages rather than one wire.
      sclk_meta <= bus.sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= bus.cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= bus.mosi0;
      mosi_sync <= mosi_meta;
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  assign sclk_rise   = sclk_sync & ~sclk_prev;
  assign sclk_fall   = ~sclk_sync & sclk_prev;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_sync & cs_prev;
  assign cs_rise     = cs_sync & ~cs_prev;

  // Bit-order dependent views of the shift registers.
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-2:0] rx_keep;
  logic [DATA_WIDTH-1:0] tx_load_word;
  logic [DATA_WIDTH-1:0] tx_advanced;
  logic                  tx_head, tx_next_head, load_head;

  assign tx_load_word = tx_full ? tx_buf : '0;

  if (LSB_FIRST) begin : g_lsb_first
    assign rx_next      = {mosi_sync, rx_shift};
    assign rx_keep      = rx_next[DATA_WIDTH-1:1];
    assign tx_advanced  = {1'b0, tx_shift[DATA_WIDTH-1:1]};
    assign tx_head      = tx_shift[0];
    assign tx_next_head = tx_shift[1];
    assign load_head    = tx_load_word[0];
  end else begin : g_msb_first
    assign rx_next      = {rx_shift, mosi_sync};
    assign rx_keep      = rx_next[DATA_WIDTH-2:0];
    assign tx_advanced  = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign tx_head      = tx_shift[DATA_WIDTH-1];
    assign tx_next_head = tx_shift[DATA_WIDTH-2];
    assign load_head    = tx_load_word[DATA_WIDTH-1];
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  logic start_frame, take_sample, do_shift, frame_done, abort;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    start_frame = 1'b0;
    take_sample = 1'b0;
    do_shift    = 1'b0;
    frame_done  = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          if (sample_edge) begin
            take_sample = 1'b1;
            if (bit_cnt == LAST_CNT) begin
              frame_done = 1'b1;
              state_d    = DONE;
            end
          end
          if (shift_edge) do_shift = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit side: one-entry buffer feeding the shift register at frame start.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      // NOTE: the data registers are reset along with control; rxData must read 0
      // after reset and a cleared shifter keeps miso0 deterministic.
      tx_full       <= 1'b0;
      tx_buf        <= '0;
      tx_shift      <= '0;
      shift_pending <= 1'b0;
      miso_q        <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= start_frame & ~tx_full;
      if (start_frame) begin
        tx_shift      <= tx_load_word;
        tx_full       <= 1'b0;
        shift_pending <= CPHA;
        miso_q        <= CPHA ? 1'b0 : load_head;
      end
      if (bus.txValid && !tx_full) begin
        tx_buf  <= bus.txData;
        tx_full <= 1'b1;
      end
      // With CPHA=1 the first shift edge only presents bit 0; later ones advance.
      if (do_shift) begin
        if (shift_pending) begin
          shift_pending <= 1'b0;
          miso_q        <= tx_head;
        end else begin
          tx_shift <= tx_advanced;
          miso_q   <= tx_next_head;
        end
      end
      if (state_d == IDLE) miso_q <= 1'b0;
    end
  end

  // Receive side: a completed word is dropped if the previous one is still unread.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_overrun_q  <= 1'b0;
      frame_abort_q <= abort;
      if (start_frame) bit_cnt <= '0;
      if (take_sample) begin
        rx_shift <= rx_keep;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (rx_valid_q && bus.rxReady) rx_valid_q <= 1'b0;
      if (frame_done) begin
        if (rx_valid_q && !bus.rxReady) begin
          rx_overrun_q <= 1'b1;
        end else begin
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.miso0      = miso_q;
  assign bus.txReady    = ~tx_full;
  assign bus.rxData     = rx_data_q;
  assign bus.rxValid    = rx_valid_q;
  assign bus.rxOverrun  = rx_overrun_q;
  assign bus.txUnderrun = tx_underrun_q;
  assign bus.frameAbort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Bench for spi_slave_shift_engine: three mode variants driven by a bit-level SPI
// master, checked against a word-level model of frames, buffers and pulses.
module tb_spi_slave_shift_engine;
  localparam int DW   = 8;
  localparam int NDUT = 3;
  localparam int HALF = 8;
  // Instance k: bit k of each vector. k0 = mode 0 LSB, k1 = CPOL1 LSB, k2 = CPHA1 MSB.
  localparam logic [NDUT-1:0] CPOL_V = 3'b010;
  localparam logic [NDUT-1:0] CPHA_V = 3'b100;
  localparam logic [NDUT-1:0] LSB_V  = 3'b011;

  logic pclk = 1'b0;
  logic areset;
  always #5 pclk = ~pclk;

  logic          sclk_pin   [NDUT];
  logic          cs_pin     [NDUT];
  logic          mosi_pin   [NDUT];
  logic [DW-1:0] tx_data    [NDUT];
  logic          tx_valid   [NDUT];
  logic          rx_ready   [NDUT];
  logic          miso_w     [NDUT];
  logic          tx_ready_w [NDUT];
  logic [DW-1:0] rx_data_w  [NDUT];
  logic          rx_valid_w [NDUT];
  logic          ovr_w      [NDUT];
  logic          unr_w      [NDUT];
  logic          abt_w      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_slave_shift_engine_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.sclk      = sclk_pin[g];
    assign bus.cs        = cs_pin[g];
    assign bus.mosi0     = mosi_pin[g];
    assign bus.txData    = tx_data[g];
    assign bus.txValid   = tx_valid[g];
    assign bus.rxReady   = rx_ready[g];
    assign miso_w[g]     = bus.miso0;
    assign tx_ready_w[g] = bus.txReady;
    assign rx_data_w[g]  = bus.rxData;
    assign rx_valid_w[g] = bus.rxValid;
    assign ovr_w[g]      = bus.rxOverrun;
    assign unr_w[g]      = bus.txUnderrun;
    assign abt_w[g]      = bus.frameAbort;

    spi_slave_shift_engine #(
      .DATA_WIDTH(DW),
      .CPOL      (CPOL_V[g]),
      .CPHA      (CPHA_V[g]),
      .LSB_FIRST (LSB_V[g])
    ) u_dut (
      .pclk  (pclk),
      .areset(areset),
      .bus   (bus)
    );
  end

  // Cycles each pulse output spends high; one event must add exactly one.
  int ovr_tot [NDUT];
  int unr_tot [NDUT];
  int abt_tot [NDUT];
  always @(negedge pclk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (ovr_w[k] === 1'b1) ovr_tot[k]++;
      if (unr_w[k] === 1'b1) unr_tot[k]++;
      if (abt_w[k] === 1'b1) abt_tot[k]++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic load_tx(input int k, input logic [DW-1:0] d);
    @(negedge pclk);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    @(negedge pclk);
    tx_valid[k] = 1'b0;
  endtask

  // Bit-level master: drives mosi on its launch edge and samples miso on its capture edge.
  // nbits < DW raises cs early after that many sample edges.
  task automatic run_frame(input int k, input logic [DW-1:0] word, input int nbits,
                           output logic [DW-1:0] mw);
    logic cpol, cpha, lsb;
    int   idx;
    cpol = CPOL_V[k];
    cpha = CPHA_V[k];
    lsb  = LSB_V[k];
    mw   = '0;
    @(negedge pclk);
    if (!cpha) mosi_pin[k] = lsb ? word[0] : word[DW-1];
    cs_pin[k] = 1'b0;
    repeat (HALF) @(negedge pclk);
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : DW - 1 - i;
      if (cpha) mosi_pin[k] = word[idx];
      else      mw[idx] = miso_w[k];
      sclk_pin[k] = ~cpol;
      repeat (HALF) @(negedge pclk);
      if (cpha)          mw[idx] = miso_w[k];
      else if (i < DW-1) mosi_pin[k] = word[lsb ? i + 1 : DW - 2 - i];
      sclk_pin[k] = cpol;
      repeat (HALF) @(negedge pclk);
    end
    cs_pin[k] = 1'b1;
    repeat (HALF) @(negedge pclk);
  endtask

  task automatic do_frame(input int k, input bit load, input logic [DW-1:0] tx,
                          input logic [DW-1:0] word, input int nbits,
                          output logic [DW-1:0] mw, output int d_ovr, output int d_unr,
                          output int d_abt);
    int o0, u0, a0;
    if (load) begin
      load_tx(k, tx);
      check($sformatf("dut%0d txReady after load", k), 32'(tx_ready_w[k]), 32'd0);
    end
    o0 = ovr_tot[k];
    u0 = unr_tot[k];
    a0 = abt_tot[k];
    run_frame(k, word, nbits, mw);
    d_ovr = ovr_tot[k] - o0;
    d_unr = unr_tot[k] - u0;
    d_abt = abt_tot[k] - a0;
    check($sformatf("dut%0d txReady after frame", k), 32'(tx_ready_w[k]), 32'd1);
  endtask

  task automatic pop_rx(input int k);
    @(negedge pclk);
    rx_ready[k] = 1'b1;
    @(negedge pclk);
    rx_ready[k] = 1'b0;
    check($sformatf("dut%0d rxValid after pop", k), 32'(rx_valid_w[k]), 32'd0);
  endtask

  typedef struct {
    int            k;
    bit            load;
    logic [DW-1:0] tx;
    logic [DW-1:0] word;
    int            nbits;
    bit            pop;
    logic [DW-1:0] e_rx;
    bit            e_valid;
    int            e_ovr;
    int            e_unr;
    int            e_abt;
    logic [DW-1:0] e_miso;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int k, input bit load, input logic [DW-1:0] tx,
                         input logic [DW-1:0] word, input int nbits, input bit pop,
                         input logic [DW-1:0] e_rx, input bit e_valid, input int e_ovr,
                         input int e_unr, input int e_abt, input logic [DW-1:0] e_miso);
    vec_t v;
    v.k = k; v.load = load; v.tx = tx; v.word = word; v.nbits = nbits; v.pop = pop;
    v.e_rx = e_rx; v.e_valid = e_valid; v.e_ovr = e_ovr; v.e_unr = e_unr;
    v.e_abt = e_abt; v.e_miso = e_miso;
    vecs.push_back(v);
  endtask

  // Word-level model for the random phase.
  logic [DW-1:0] m_data  [NDUT];
  bit            m_valid [NDUT];

  initial begin
    vec_t          v;
    logic [DW-1:0] mw, tx, word, exp_tx;
    int            d_ovr, d_unr, d_abt, k, nbits;
    bit            load, pop, exp_ovr, exp_abt;

    areset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      sclk_pin[i] = CPOL_V[i];
      cs_pin[i]   = 1'b1;
      mosi_pin[i] = 1'b0;
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
      rx_ready[i] = 1'b0;
    end
    repeat (3) @(negedge pclk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d reset rxValid", i), 32'(rx_valid_w[i]), 32'd0);
      check($sformatf("dut%0d reset rxData", i), 32'(rx_data_w[i]), 32'd0);
      check($sformatf("dut%0d reset txReady", i), 32'(tx_ready_w[i]), 32'd1);
      check($sformatf("dut%0d reset miso0", i), 32'(miso_w[i]), 32'd0);
      check($sformatf("dut%0d reset pulses", i), {29'd0, ovr_w[i], unr_w[i], abt_w[i]}, 32'd0);
    end
    areset = 1'b1;
    repeat (4) @(negedge pclk);

    //      k load tx     word   nb pop  e_rx   vld ovr unr abt e_miso
    add_vec(0, 1, 8'h3C, 8'hA5, 8, 1, 8'hA5, 1, 0, 0, 0, 8'h3C);
    add_vec(1, 1, 8'h96, 8'h5A, 8, 1, 8'h5A, 1, 0, 0, 0, 8'h96);
    add_vec(0, 1, 8'h81, 8'hFF, 3, 0, 8'hA5, 0, 0, 0, 1, 8'h00);
    add_vec(0, 0, 8'h00, 8'hFF, 8, 1, 8'hFF, 1, 0, 1, 0, 8'h00);
    add_vec(0, 1, 8'h55, 8'h11, 8, 0, 8'h11, 1, 0, 0, 0, 8'h55);
    add_vec(0, 1, 8'hAA, 8'h22, 8, 1, 8'h11, 1, 1, 0, 0, 8'hAA);
    add_vec(0, 0, 8'h00, 8'h6D, 8, 1, 8'h6D, 1, 0, 1, 0, 8'h00);
    add_vec(2, 1, 8'hC6, 8'h3B, 8, 1, 8'h3B, 1, 0, 0, 0, 8'hC6);
    add_vec(2, 1, 8'h12, 8'h77, 5, 0, 8'h3B, 0, 0, 0, 1, 8'h00);
    add_vec(2, 0, 8'h00, 8'h80, 8, 1, 8'h80, 1, 0, 1, 0, 8'h00);
    add_vec(1, 1, 8'h01, 8'hE7, 7, 0, 8'h5A, 0, 0, 0, 1, 8'h00);
    add_vec(1, 1, 8'h7E, 8'h00, 8, 1, 8'h00, 1, 0, 0, 0, 8'h7E);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_frame(v.k, v.load, v.tx, v.word, v.nbits, mw, d_ovr, d_unr, d_abt);
      check($sformatf("v%0d rxData", i), 32'(rx_data_w[v.k]), 32'(v.e_rx));
      check($sformatf("v%0d rxValid", i), 32'(rx_valid_w[v.k]), 32'(v.e_valid));
      check($sformatf("v%0d rxOverrun cycles", i), d_ovr, v.e_ovr);
      check($sformatf("v%0d txUnderrun cycles", i), d_unr, v.e_unr);
      check($sformatf("v%0d frameAbort cycles", i), d_abt, v.e_abt);
      if (v.nbits == DW) check($sformatf("v%0d miso word", i), 32'(mw), 32'(v.e_miso));
      if (v.pop) pop_rx(v.k);
    end

    // Asynchronous reset in the middle of a frame, with a word pending and the buffer full.
    do_frame(0, 1'b0, 8'h00, 8'h99, DW, mw, d_ovr, d_unr, d_abt);
    check("pre-reset rxValid", 32'(rx_valid_w[0]), 32'd1);
    load_tx(0, 8'h3C);
    fork
      run_frame(0, 8'h5A, DW, mw);
      begin
        @(negedge pclk);
        repeat (20) @(negedge pclk);
        tx_data[0]  = 8'h77;
        tx_valid[0] = 1'b1;
        @(negedge pclk);
        tx_valid[0] = 1'b0;
        repeat (55) @(negedge pclk);
        check("mid-frame txReady", 32'(tx_ready_w[0]), 32'd0);
        check("mid-frame miso0 bit4", 32'(miso_w[0]), 32'd1);
        areset = 1'b0;
        #1;
        check("reset rxValid immediate", 32'(rx_valid_w[0]), 32'd0);
        check("reset miso0 immediate", 32'(miso_w[0]), 32'd0);
        check("reset txReady immediate", 32'(tx_ready_w[0]), 32'd1);
        check("reset rxData immediate", 32'(rx_data_w[0]), 32'd0);
      end
    join
    @(negedge pclk);
    areset = 1'b1;
    repeat (4) @(negedge pclk);
    do_frame(0, 1'b0, 8'h00, 8'hC3, DW, mw, d_ovr, d_unr, d_abt);
    check("post-reset rxData", 32'(rx_data_w[0]), 32'hC3);
    check("post-reset rxValid", 32'(rx_valid_w[0]), 32'd1);
    check("post-reset txUnderrun cycles", d_unr, 1);
    pop_rx(0);

    m_data[0] = 8'hC3;
    m_data[1] = '0;
    m_data[2] = '0;
    for (int i = 0; i < NDUT; i++) m_valid[i] = 1'b0;

    for (int n = 0; n < 40; n++) begin
      k     = int'($urandom_range(0, NDUT - 1));
      load  = ($urandom_range(0, 3) != 0);
      tx    = DW'($urandom);
      word  = DW'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
      pop   = ($urandom_range(0, 1) == 1);

      exp_tx  = load ? tx : '0;
      exp_abt = (nbits < DW);
      exp_ovr = 1'b0;
      if (!exp_abt) begin
        if (m_valid[k]) exp_ovr = 1'b1;
        else begin
          m_data[k]  = word;
          m_valid[k] = 1'b1;
        end
      end

      do_frame(k, load, tx, word, nbits, mw, d_ovr, d_unr, d_abt);
      check($sformatf("r%0d dut%0d rxData", n, k), 32'(rx_data_w[k]), 32'(m_data[k]));
      check($sformatf("r%0d dut%0d rxValid", n, k), 32'(rx_valid_w[k]), 32'(m_valid[k]));
      check($sformatf("r%0d dut%0d rxOverrun cycles", n, k), d_ovr, int'(exp_ovr));
      check($sformatf("r%0d dut%0d txUnderrun cycles", n, k), d_unr, int'(!load));
      check($sformatf("r%0d dut%0d frameAbort cycles", n, k), d_abt, int'(exp_abt));
      if (!exp_abt) check($sformatf("r%0d dut%0d miso word", n, k), 32'(mw), 32'(exp_tx));
      if (pop && m_valid[k]) begin
        pop_rx(k);
        m_valid[k] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
